// File: rtl/pipe_pkg.sv
// Shared pipeline types for the five-stage MIPS core.
// The EX/MEM bundle and its bubble are reused by neighbouring latches.
package pipe_pkg;

    localparam int REGNUM_W = 6;
    localparam int DATA_W   = 32;

    localparam logic [REGNUM_W-1:0] ZERO_REG = 6'd0;

    typedef struct packed {
        logic                valid;
        logic                load;
        logic                store;
        logic                regwrite;
        logic [REGNUM_W-1:0] regnum;
        logic [DATA_W-1:0]   alu;
        logic [DATA_W-1:0]   sdata;
        logic [DATA_W-1:0]   pc;
    } ex_mem_t;

    // Register number zero guarantees no forwarding match on a bubble.
    localparam ex_mem_t EX_MEM_BUBBLE = '{
        valid:    1'b0,
        load:     1'b0,
        store:    1'b0,
        regwrite: 1'b0,
        regnum:   ZERO_REG,
        alu:      '0,
        sdata:    '0,
        pc:       '0
    };

    typedef enum logic {
        FP_IDLE,
        FP_PEND
    } fp_state_t;

    function automatic ex_mem_t keep_or_bubble(logic v, ex_mem_t s);
        return v ? s : EX_MEM_BUBBLE;
    endfunction

endpackage

// File: rtl/ex_mem_latch_if.sv
// EX->MEM latch bus: EX-side inputs, hazard controls, MEM-side outputs.
// master drives EX/control, slave is the latch itself.
interface ex_mem_latch_if;
    import pipe_pkg::*;

    logic                Halt;
    logic                Flush;
    logic                LoadStore;
    logic                EXValid;
    logic [REGNUM_W-1:0] EXRegisterNumber;
    logic [DATA_W-1:0]   EXAluResult;
    logic [DATA_W-1:0]   EXStoreData;
    logic                EXLoad;
    logic                EXStore;
    logic                EXRegWrite;
    logic [DATA_W-1:0]   EXPC;

    logic                MEMValid;
    logic                MEMLoad;
    logic                MEMStore;
    logic                MEMRegWrite;
    logic [REGNUM_W-1:0] MEMRegisterNumber;
    logic [DATA_W-1:0]   MEMAluResultData;
    logic [DATA_W-1:0]   MEMStoreData;
    logic [DATA_W-1:0]   MEMPC;
    logic                StallFront;

    modport master (
        output Halt, Flush, LoadStore, EXValid,
        output EXRegisterNumber, EXAluResult, EXStoreData,
        output EXLoad, EXStore, EXRegWrite, EXPC,
        input  MEMValid, MEMLoad, MEMStore, MEMRegWrite,
        input  MEMRegisterNumber, MEMAluResultData,
        input  MEMStoreData, MEMPC, StallFront
    );

    modport slave (
        input  Halt, Flush, LoadStore, EXValid,
        input  EXRegisterNumber, EXAluResult, EXStoreData,
        input  EXLoad, EXStore, EXRegWrite, EXPC,
        output MEMValid, MEMLoad, MEMStore, MEMRegWrite,
        output MEMRegisterNumber, MEMAluResultData,
        output MEMStoreData, MEMPC, StallFront
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_latch.sv
// EX->MEM pipeline register with flush/load-use bubbles, halt hold
// and a flush remembered across halt.
module ex_mem_latch
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_mem_latch_if.slave    bus,
    output logic [CNT_W-1:0] LoadUseBubbles,
    output logic [CNT_W-1:0] FlushBubbles
);

    fp_state_t state;
    fp_state_t state_nx;
    ex_mem_t   ex_in;
    ex_mem_t   mem_q;
    logic      flush_eff;
    logic      fl_inc;
    logic      lu_inc;

    always_comb begin
        ex_in = '{
            valid:    bus.EXValid,
            load:     bus.EXLoad,
            store:    bus.EXStore,
            regwrite: bus.EXRegWrite,
            regnum:   bus.EXRegisterNumber,
            alu:      bus.EXAluResult,
            sdata:    bus.EXStoreData,
            pc:       bus.EXPC
        };
    end

    assign flush_eff = bus.Flush | (state == FP_PEND);
    assign fl_inc    = ~bus.Halt & flush_eff;
    assign lu_inc    = ~bus.Halt & ~flush_eff & bus.LoadStore;

    // A pending flush outranks the hazard, so front end need not stall.
    assign bus.StallFront = bus.Halt | (bus.LoadStore & ~flush_eff);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FP_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FP_IDLE: if (bus.Halt && bus.Flush) state_nx = FP_PEND;
            FP_PEND: if (!bus.Halt) state_nx = FP_IDLE;
            default: state_nx = FP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= EX_MEM_BUBBLE;
        end else if (bus.Halt) begin
            mem_q <= mem_q;
        end else if (flush_eff || bus.LoadStore) begin
            mem_q <= EX_MEM_BUBBLE;
        end else begin
            mem_q <= keep_or_bubble(bus.EXValid, ex_in);
        end
    end

    assign bus.MEMValid          = mem_q.valid;
    assign bus.MEMLoad           = mem_q.load;
    assign bus.MEMStore          = mem_q.store;
    assign bus.MEMRegWrite       = mem_q.regwrite;
    assign bus.MEMRegisterNumber = mem_q.regnum;
    assign bus.MEMAluResultData  = mem_q.alu;
    assign bus.MEMStoreData      = mem_q.sdata;
    assign bus.MEMPC             = mem_q.pc;

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lu_inc),
        .count (LoadUseBubbles)
    );

    sat_counter #(.W(CNT_W)) u_fl_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fl_inc),
        .count (FlushBubbles)
    );

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed vector bench for ex_mem_latch (CNT_W=4 so saturation is
// reachable), plus hand sequences for halt/flush/reset corners.
module tb_ex_mem_latch;
    import pipe_pkg::*;

    typedef struct {
        logic    halt;
        logic    flush;
        logic    ls;
        ex_mem_t ex;
        logic    exp_stall;
        ex_mem_t exp;
        int      exp_lu;
        int      exp_fl;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] lub;
    logic [3:0] flb;
    int         tests = 0;
    int         fails = 0;
    vec_t       vecs[8];
    ex_mem_t    held;
    ex_mem_t    allones;

    always #5 clk = ~clk;

    ex_mem_latch_if bus();

    ex_mem_latch #(.CNT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .LoadUseBubbles (lub),
        .FlushBubbles   (flb)
    );

    function automatic ex_mem_t mk(logic v, logic ld, logic st,
                                   logic rw, logic [5:0] r,
                                   logic [31:0] a, logic [31:0] s,
                                   logic [31:0] p);
        ex_mem_t e;
        e.valid = v;
        e.load = ld;
        e.store = st;
        e.regwrite = rw;
        e.regnum = r;
        e.alu = a;
        e.sdata = s;
        e.pc = p;
        return e;
    endfunction

    function automatic ex_mem_t mem_now();
        return mk(bus.MEMValid, bus.MEMLoad, bus.MEMStore,
                  bus.MEMRegWrite, bus.MEMRegisterNumber,
                  bus.MEMAluResultData, bus.MEMStoreData, bus.MEMPC);
    endfunction

    task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic drive(logic h, logic f, logic ls, ex_mem_t e);
        bus.Halt = h;
        bus.Flush = f;
        bus.LoadStore = ls;
        bus.EXValid = e.valid;
        bus.EXLoad = e.load;
        bus.EXStore = e.store;
        bus.EXRegWrite = e.regwrite;
        bus.EXRegisterNumber = e.regnum;
        bus.EXAluResult = e.alu;
        bus.EXStoreData = e.sdata;
        bus.EXPC = e.pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ex_mem_t ld8, use8, oth, inv, st0, r12, r13;
        ld8  = mk(1, 1, 0, 1, 6'd8,  32'h2000, 32'h0, 32'h104);
        use8 = mk(1, 0, 0, 1, 6'd9,  32'h55,   32'h0, 32'h108);
        oth  = mk(1, 0, 0, 1, 6'd10, 32'h77,   32'h1, 32'h10C);
        inv  = mk(0, 1, 1, 1, 6'd3,  32'hAAAA, 32'hBB, 32'h110);
        st0  = mk(1, 0, 1, 0, 6'd0,  32'h3000, 32'hCAFE, 32'h200);
        r12  = mk(1, 0, 0, 1, 6'd12, 32'hC0,   32'h0, 32'h300);
        r13  = mk(1, 0, 0, 1, 6'd13, 32'hD0,   32'h0, 32'h400);

        vecs[0] = '{0, 0, 0, mk(1, 0, 0, 1, 6'd5, 32'h1234, 32'hBEEF, 32'h100),
                    0, mk(1, 0, 0, 1, 6'd5, 32'h1234, 32'hBEEF, 32'h100), 0, 0};
        vecs[1] = '{0, 0, 0, ld8,  0, ld8,           0, 0};
        vecs[2] = '{0, 0, 1, use8, 1, EX_MEM_BUBBLE, 1, 0};
        vecs[3] = '{0, 0, 0, use8, 0, use8,          1, 0};
        vecs[4] = '{1, 0, 0, oth,  1, use8,          1, 0};
        vecs[5] = '{0, 0, 0, inv,  0, EX_MEM_BUBBLE, 1, 0};
        vecs[6] = '{0, 1, 1, oth,  0, EX_MEM_BUBBLE, 1, 1};
        vecs[7] = '{0, 0, 0, st0,  0, st0,           1, 1};

        // Reset with every input high.
        allones = '1;
        rst_n = 1'b0;
        drive(1, 1, 1, allones);
        tick();
        tick();
        chk("rst_mem", 128'(mem_now()), 128'(EX_MEM_BUBBLE));
        chk("rst_lu", 128'(lub), 128'(0));
        chk("rst_fl", 128'(flb), 128'(0));
        chk("rst_stall", 128'(bus.StallFront), 128'(1));
        rst_n = 1'b1;
        drive(0, 0, 0, '0);
        #1;
        chk("rel_stall", 128'(bus.StallFront), 128'(0));
        tick();
        chk("rel_mem", 128'(mem_now()), 128'(EX_MEM_BUBBLE));
        chk("rel_fl", 128'(flb), 128'(0));

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].halt, vecs[i].flush, vecs[i].ls, vecs[i].ex);
            #1;
            chk($sformatf("v%0d_stall", i), 128'(bus.StallFront),
                128'(vecs[i].exp_stall));
            tick();
            chk($sformatf("v%0d_mem", i), 128'(mem_now()),
                128'(vecs[i].exp));
            chk($sformatf("v%0d_lu", i), 128'(lub), 128'(vecs[i].exp_lu));
            chk($sformatf("v%0d_fl", i), 128'(flb), 128'(vecs[i].exp_fl));
        end

        // Flush arrives during a 3-cycle halt and must survive it.
        held = st0;
        drive(1, 1, 0, r12);
        #1;
        chk("hf_stall", 128'(bus.StallFront), 128'(1));
        tick();
        chk("hf_hold1", 128'(mem_now()), 128'(held));
        drive(1, 0, 0, r12);
        tick();
        chk("hf_hold2", 128'(mem_now()), 128'(held));
        tick();
        chk("hf_hold3", 128'(mem_now()), 128'(held));
        chk("hf_fl_held", 128'(flb), 128'(1));
        drive(0, 0, 1, r12);
        #1;
        chk("hf_pend_stall", 128'(bus.StallFront), 128'(0));
        tick();
        chk("hf_bubble", 128'(mem_now()), 128'(EX_MEM_BUBBLE));
        chk("hf_fl", 128'(flb), 128'(2));
        chk("hf_lu", 128'(lub), 128'(1));
        drive(0, 0, 0, r12);
        tick();
        chk("hf_capture", 128'(mem_now()), 128'(r12));
        chk("hf_fl_after", 128'(flb), 128'(2));

        // Reset while a flush is pending drops it.
        drive(1, 1, 0, r12);
        tick();
        rst_n = 1'b0;
        drive(0, 0, 0, r12);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, r13);
        tick();
        chk("rp_capture", 128'(mem_now()), 128'(r13));
        chk("rp_fl", 128'(flb), 128'(0));

        // Saturation of the flush counter.
        drive(0, 1, 0, r13);
        for (int i = 0; i < 15; i++) tick();
        chk("sat_15", 128'(flb), 128'(15));
        for (int i = 0; i < 5; i++) tick();
        chk("sat_20", 128'(flb), 128'(15));
        chk("sat_lu", 128'(lub), 128'(0));
        chk("sat_mem", 128'(mem_now()), 128'(EX_MEM_BUBBLE));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
